lfsr_checker: RTL
=================

Name: lfsr_checker

Overview:
- Receive-side counterpart of the team's LFSR pattern generator: consumes a serial PRBS bitstream and self-synchronises its own LFSR to that stream.
- Once synchronised, flags and counts every bit that deviates from the predicted sequence.
- Sits at the sink end of any link or datapath driven by the LFSR, as the built-in pattern checker for lab and board bring-up.

Parameters:
- WIDTH, 8: LFSR length in bits.
- TAPS, 8'b1011_1000: feedback mask; bit i set means the bit received i+1 valid cycles ago contributes to the XOR. Default is x^8+x^6+x^5+x^4+1.
- LOCK_CNT, 16: consecutive correct predictions required to declare lock.
- LOSS_CNT, 4: consecutive mispredictions while locked that drop lock.
- CNT_W, 16: width of the error counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_bit  input  1  received serial bit.
- in_valid  input  1  in_bit is sampled only when high.
- locked  output  1  checker synchronised to the stream.
- err  output  1  one-cycle pulse, locked-state misprediction.
- err_cnt  output  CNT_W  saturating count of err pulses.

Behaviour:
- Reset (rst high at a rising edge): next cycle state=SEED, sr=0, fill/match/miss counters=0, locked=0, err=0, err_cnt=0. Reset has priority over everything, including mid-lock and mid-fill.
- Predicted bit: pred = XOR-reduce(sr & TAPS). sr[0] holds the newest bit and shifts toward sr[WIDTH-1].
- All state changes happen only on cycles with in_valid=1. With in_valid=0, all registers hold and err=0.
- All outputs are registered: a response to a bit sampled at edge N is visible after edge N.
- SEED state:
  - Shift in_bit into sr; fill_cnt++.
  - On the WIDTH-th valid bit, go to TRACK with match_cnt=0.
  - No comparisons are made; err=0.
- TRACK state:
  - Shift in the received bit (continuous resync).
  - in_bit==pred: match_cnt++. On the LOCK_CNT-th consecutive match, go to LOCKED, locked=1, miss_cnt=0.
  - Mismatch: match_cnt=0, stay in TRACK. No err, no count.
  - Degenerate case: if the updated sr is all zero, return to SEED with fill_cnt=0. A stuck-at-0 input never locks.
- LOCKED state (flywheel):
  - Shift pred, not in_bit, so an isolated error does not corrupt the following predictions.
  - Mismatch: err=1 for one cycle; err_cnt++ (saturates at 2^CNT_W-1, no wrap); miss_cnt++.
  - Match: miss_cnt=0.
  - On the LOSS_CNT-th consecutive miss: go to SEED, locked=0, fill_cnt=0, sr=0. err_cnt is retained.
- Lock latency from SEED with a clean stream: WIDTH+LOCK_CNT valid bits, i.e. 24 with the defaults.
- Counters are sized ceil(log2(max+1)). LOCK_CNT and LOSS_CNT must be ≥1.

Optional Feature:
- Macro LFSR_CHECKER_CLR_EN.
- Defined:
  - Adds port clr (input, 1): synchronous clear of err_cnt only.
  - clr works regardless of in_valid.
  - State, sr and locked are unaffected.
  - If clr and an err event occur in the same cycle, err_cnt=1 (the new error is kept).
- Undefined: no clr port; err_cnt clears only on rst.

Test Plan:
1. Reset: rst=1 for 2 cycles mid-stream while locked -> next cycle locked=0, err=0, err_cnt=0; relock requires a full 24 valid bits.
2. Clean lock: generator seed 8'hFF, in_valid=1 every cycle -> locked rises after the 24th bit's edge; err_cnt=0 after 1000 bits.
3. Single flip: invert bit 100 while locked -> err high exactly one cycle, err_cnt=1, locked stays 1, no further errors.
4. All-zero input for 64 valid bits after reset -> locked never asserts; err_cnt=0.
5. Loss and relock:
   - Stimulus: invert every bit from bit 200 while locked.
   - Required: locked drops after the 4th miss with err_cnt=4.
   - Stimulus: restore the clean stream.
   - Required: relock 24 valid bits later; err_cnt still 4.
6. Gaps: in_valid high one cycle in three with a clean stream -> lock after exactly 24 valid bits (72 cycles); no state change on invalid cycles.

Source files
------------

// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side PRBS checker.
// Locks its own LFSR onto an incoming serial PRBS stream, then flags and counts
// every bit that differs from the predicted sequence.
// Optional macro LFSR_CHECKER_CLR_EN adds a 'clr' input that synchronously
// clears err_cnt without touching the synchroniser state.

module lfsr_checker #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = 8'b1011_1000,
    parameter int               LOCK_CNT = 16,
    parameter int               LOSS_CNT = 4,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
`ifdef LFSR_CHECKER_CLR_EN
    input  logic             clr,
`endif
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    // Shared decode of the current cycle: prediction and the two shift candidates.
    logic               pred;
    logic               hit;
    logic [WIDTH-1:0]   sr_rx;
    logic [WIDTH-1:0]   sr_fly;
    logic [FILL_W-1:0]  fill_inc;
    logic [MATCH_W-1:0] match_inc;
    logic [MISS_W-1:0]  miss_inc;
    logic               fill_done;
    logic               match_done;
    logic               miss_done;
    logic               sr_rx_zero;
    logic [CNT_W-1:0]   cnt_base;
    logic [CNT_W-1:0]   cnt_sat_inc;

    // sr[0] is the newest bit; the taps select older bits for the prediction.
    assign pred        = ^(sr_q & TAPS);
    assign hit         = (in_bit == pred);
    assign sr_rx       = {sr_q[WIDTH-2:0], in_bit};
    assign sr_fly      = {sr_q[WIDTH-2:0], pred};
    assign sr_rx_zero  = (sr_rx == '0);

    assign fill_inc    = fill_q + 1'b1;
    assign match_inc   = match_q + 1'b1;
    assign miss_inc    = miss_q + 1'b1;
    assign fill_done   = (fill_inc == FILL_W'(WIDTH));
    assign match_done  = (match_inc == MATCH_W'(LOCK_CNT));
    assign miss_done   = (miss_inc == MISS_W'(LOSS_CNT));

`ifdef LFSR_CHECKER_CLR_EN
    // A clear wipes the old count first so an error in the same cycle still lands as 1.
    assign cnt_base    = clr ? '0 : err_cnt_q;
`else
    assign cnt_base    = err_cnt_q;
`endif

    // The count sticks at all-ones instead of wrapping back to zero.
    assign cnt_sat_inc = (cnt_base == {CNT_W{1'b1}}) ? cnt_base : cnt_base + 1'b1;

    // State register; reset forces a fresh seed fill from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision; nothing moves on cycles without a valid bit.
    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            case (state_q)
                ST_SEED: begin
                    if (fill_done) begin
                        state_d = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (sr_rx_zero) begin
                        state_d = ST_SEED;
                    end else if (hit && match_done) begin
                        state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (!hit && miss_done) begin
                        state_d = ST_SEED;
                    end
                end
                default: begin
                    state_d = ST_SEED;
                end
            endcase
        end
    end

    // Datapath next values: shift register, run counters and error reporting.
    always_comb begin
        sr_d      = sr_q;
        fill_d    = fill_q;
        match_d   = match_q;
        miss_d    = miss_q;
        err_d     = 1'b0;
        err_cnt_d = cnt_base;
        if (in_valid) begin
            case (state_q)
                ST_SEED: begin
                    sr_d = sr_rx;
                    if (fill_done) begin
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_inc;
                    end
                end
                ST_TRACK: begin
                    sr_d = sr_rx;
                    if (sr_rx_zero) begin
                        fill_d  = '0;
                        match_d = '0;
                    end else if (hit) begin
                        if (match_done) begin
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            match_d = match_inc;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                ST_LOCKED: begin
                    sr_d = sr_fly;
                    if (hit) begin
                        miss_d = '0;
                    end else begin
                        err_d     = 1'b1;
                        err_cnt_d = cnt_sat_inc;
                        if (miss_done) begin
                            miss_d = '0;
                            fill_d = '0;
                            sr_d   = '0;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                end
                default: begin
                    sr_d    = '0;
                    fill_d  = '0;
                    match_d = '0;
                    miss_d  = '0;
                end
            endcase
        end
    end

    // Datapath registers; reset clears everything including the error count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q      <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            sr_q      <= sr_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Outputs come straight from registers; locked is simply "in the flywheel state".
    always_comb begin
        locked  = (state_q == ST_LOCKED);
        err     = err_q;
        err_cnt = err_cnt_q;
    end

endmodule
